// File: rtl/xsleenacore_palram_arbiter.sv
// Palette RAM arbiter: shares the split LSB/MSB palette RAMs between pixel fetch,
// a small CPU write buffer and blocking CPU reads, with a starvation escape for the CPU.
module xsleenacore_palram_arbiter #(
    parameter int WFIFO_DEPTH = 2,
    parameter int STARVE_MAX  = 15
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        PIX_CEN,
    input  logic        BLKn,
    input  logic [8:0]  VID_ADDR,
    output logic [11:0] VID_DATA,
    output logic        VID_HOLD,
    input  logic        CPU_REQ,
    input  logic        CPU_RW,
    input  logic [9:0]  CPU_AB,
    input  logic [7:0]  CPU_DIN,
    output logic [7:0]  CPU_DOUT,
    output logic        CPU_ACK,
    output logic        CPU_WAITn,
    output logic [8:0]  RAM_ADDR,
    output logic [7:0]  RAM_DIN,
    output logic        RAM_LSB_CE,
    output logic        RAM_MSB_CE,
    output logic        RAM_WE,
    input  logic [7:0]  RAM_LSB_Q,
    input  logic [7:0]  RAM_MSB_Q
);

    localparam int AW = (WFIFO_DEPTH > 2) ? $clog2(WFIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(WFIFO_DEPTH);
    localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_CAPTURE, S_ACK} state_t;

    typedef struct packed {
        logic [9:0] ab;
        logic [7:0] din;
    } wr_entry_t;

    state_t     state, state_nxt;
    logic [1:0] rst_sync;
    logic       rst_ok;

    wr_entry_t  fifo_mem [WFIFO_DEPTH];
    wr_entry_t  fifo_head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic       fifo_empty, fifo_full;

    logic [7:0] starve_cnt;
    logic       video_slot, demand, starve, vid_own, free_slot;
    logic       drain, rd_issue, push, wr_stall;
    logic [8:0] addr_q;
    logic       rd_bank;
    logic       vid_s1, blank_s1, hold_s1;

    // Reset release is resynchronised; nothing owns the RAM until rst_ok rises.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok = rst_sync[1];

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Ownership: video > write drain > CPU read, unless the CPU has been starved.
    assign video_slot = PIX_CEN & BLKn;
    assign demand     = CPU_REQ | ~fifo_empty;
    assign starve     = video_slot & demand & (starve_cnt == STARVE_LIM);
    assign vid_own    = rst_ok & video_slot & ~starve;
    assign free_slot  = rst_ok & ~vid_own;
    assign drain      = free_slot & ~fifo_empty;
    assign rd_issue   = free_slot & fifo_empty & (state == S_ISSUE) & CPU_REQ;
    assign push       = rst_ok & (state == S_IDLE) & CPU_REQ & ~CPU_RW & (~fifo_full | drain);
    assign wr_stall   = rst_ok & (state == S_IDLE) & CPU_REQ & ~CPU_RW & fifo_full & ~drain;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{ab: CPU_AB, din: CPU_DIN};
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            case ({push, drain})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Counts consecutive video wins against a waiting CPU; any freed cycle restarts it.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)                 starve_cnt <= '0;
        else if (vid_own & demand) starve_cnt <= starve_cnt + 1'b1;
        else                       starve_cnt <= '0;
    end

    always_comb begin
        RAM_ADDR   = addr_q;
        RAM_DIN    = 8'h00;
        RAM_LSB_CE = 1'b0;
        RAM_MSB_CE = 1'b0;
        RAM_WE     = 1'b0;
        if (vid_own) begin
            RAM_ADDR   = VID_ADDR;
            RAM_LSB_CE = 1'b1;
            RAM_MSB_CE = 1'b1;
        end else if (drain) begin
            RAM_ADDR   = fifo_head.ab[8:0];
            RAM_DIN    = fifo_head.din;
            RAM_WE     = 1'b1;
            RAM_LSB_CE = ~fifo_head.ab[9];
            RAM_MSB_CE = fifo_head.ab[9];
        end else if (rd_issue) begin
            RAM_ADDR   = CPU_AB[8:0];
            RAM_LSB_CE = ~CPU_AB[9];
            RAM_MSB_CE = CPU_AB[9];
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) addr_q <= '0;
        else       addr_q <= RAM_ADDR;
    end

    // Pixel pipe: slot in t, RAM data in t+1, VID_DATA/VID_HOLD visible in t+2.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            vid_s1   <= 1'b0;
            blank_s1 <= 1'b0;
            hold_s1  <= 1'b0;
            VID_DATA <= '0;
            VID_HOLD <= 1'b0;
        end else begin
            vid_s1   <= vid_own;
            blank_s1 <= rst_ok & PIX_CEN & ~BLKn;
            hold_s1  <= rst_ok & starve;
            VID_HOLD <= hold_s1;
            if (vid_s1)        VID_DATA <= {RAM_MSB_Q[3:0], RAM_LSB_Q};
            else if (blank_s1) VID_DATA <= '0;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rd_bank  <= 1'b0;
            CPU_DOUT <= 8'hFF;
        end else begin
            if (rd_issue) rd_bank <= CPU_AB[9];
            if (state == S_CAPTURE && CPU_REQ) CPU_DOUT <= rd_bank ? RAM_MSB_Q : RAM_LSB_Q;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rst_ok && CPU_REQ) begin
                    if (CPU_RW)    state_nxt = fifo_empty ? S_ISSUE : S_DRAIN;
                    else if (push) state_nxt = S_ACK;
                end
            end
            S_DRAIN:   if (!CPU_REQ) state_nxt = S_IDLE; else if (fifo_empty) state_nxt = S_ISSUE;
            S_ISSUE:   if (!CPU_REQ) state_nxt = S_IDLE; else if (rd_issue) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = CPU_REQ ? S_ACK : S_IDLE;
            S_ACK:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CPU_ACK   = 1'b0;
        CPU_WAITn = 1'b1;
        case (state)
            S_IDLE:                      CPU_WAITn = ~wr_stall;
            S_DRAIN, S_ISSUE, S_CAPTURE: CPU_WAITn = 1'b0;
            S_ACK:                       CPU_ACK   = 1'b1;
            default:                     CPU_WAITn = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_xsleenacore_palram_arbiter.sv
// Directed bench for the palette RAM arbiter with a behavioural synchronous RAM pair.
module tb_xsleenacore_palram_arbiter;

    logic        clk = 1'b0;
    logic        RSTn, PIX_CEN, BLKn, CPU_REQ, CPU_RW;
    logic [8:0]  VID_ADDR, RAM_ADDR;
    logic [11:0] VID_DATA;
    logic        VID_HOLD, CPU_ACK, CPU_WAITn, RAM_LSB_CE, RAM_MSB_CE, RAM_WE;
    logic [9:0]  CPU_AB;
    logic [7:0]  CPU_DIN, CPU_DOUT, RAM_DIN;
    logic [7:0]  RAM_LSB_Q = 8'h00, RAM_MSB_Q = 8'h00;

    always #5 clk = ~clk;

    xsleenacore_palram_arbiter #(.WFIFO_DEPTH(2), .STARVE_MAX(15)) dut (
        .clk(clk), .RSTn(RSTn), .PIX_CEN(PIX_CEN), .BLKn(BLKn), .VID_ADDR(VID_ADDR),
        .VID_DATA(VID_DATA), .VID_HOLD(VID_HOLD), .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW),
        .CPU_AB(CPU_AB), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK),
        .CPU_WAITn(CPU_WAITn), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
        .RAM_LSB_CE(RAM_LSB_CE), .RAM_MSB_CE(RAM_MSB_CE), .RAM_WE(RAM_WE),
        .RAM_LSB_Q(RAM_LSB_Q), .RAM_MSB_Q(RAM_MSB_Q)
    );

    logic [7:0]  lsb_mem [512];
    logic [7:0]  msb_mem [512];
    logic [17:0] wlog [$];
    int          wcyc [$];
    int          hold_cyc [$];
    int          cyc = 0, lsb_rd = 0, msb_rd = 0, ack_n = 0;
    int          n_vec = 0, n_err = 0;

    // RAM model: contents preloaded while reset is low, writes logged as {bank, addr, data}.
    always @(posedge clk) begin
        if (!RSTn) begin
            for (int i = 0; i < 512; i++) begin
                lsb_mem[i] <= i[7:0] ^ 8'h5A;
                msb_mem[i] <= i[7:0];
            end
            lsb_mem[9'h012] <= 8'hA5; msb_mem[9'h012] <= 8'h03;
            lsb_mem[9'h1FF] <= 8'h3C; msb_mem[9'h1FF] <= 8'hF9;
            lsb_mem[9'h010] <= 8'h77;
        end else begin
            if (RAM_LSB_CE) begin
                if (RAM_WE) begin
                    lsb_mem[RAM_ADDR] <= RAM_DIN;
                    wlog.push_back({1'b0, RAM_ADDR, RAM_DIN}); wcyc.push_back(cyc);
                end else RAM_LSB_Q <= lsb_mem[RAM_ADDR];
            end
            if (RAM_MSB_CE) begin
                if (RAM_WE) begin
                    msb_mem[RAM_ADDR] <= RAM_DIN;
                    wlog.push_back({1'b1, RAM_ADDR, RAM_DIN}); wcyc.push_back(cyc);
                end else RAM_MSB_Q <= msb_mem[RAM_ADDR];
            end
        end
        if (RAM_LSB_CE && !RAM_MSB_CE && !RAM_WE) lsb_rd <= lsb_rd + 1;
        if (RAM_MSB_CE && !RAM_LSB_CE && !RAM_WE) msb_rd <= msb_rd + 1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (VID_HOLD) hold_cyc.push_back(cyc);
        if (CPU_ACK)  ack_n = ack_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Holds the request until ACK (bounded), then drops it in the following cycle.
    task automatic cpu_xact(input logic rw, input logic [9:0] ab, input logic [7:0] din,
                            output int lat, output int stalls, output logic [7:0] dout);
        lat = -1; stalls = 0; dout = 8'h00;
        CPU_REQ = 1'b1; CPU_RW = rw; CPU_AB = ab; CPU_DIN = din;
        for (int k = 0; k < 100; k++) begin
            smp();
            if (!CPU_WAITn) stalls++;
            if (CPU_ACK) begin
                lat = k; dout = CPU_DOUT;
                break;
            end
            nxt();
        end
        nxt();
        CPU_REQ = 1'b0;
    endtask

    task automatic check_reset_outs(input string pfx);
        check({pfx, "_vdata"}, 32'(VID_DATA), 32'h0);
        check({pfx, "_vhold"}, 32'(VID_HOLD), 32'h0);
        check({pfx, "_dout"},  32'(CPU_DOUT), 32'hFF);
        check({pfx, "_ack"},   32'(CPU_ACK), 32'h0);
        check({pfx, "_waitn"}, 32'(CPU_WAITn), 32'h1);
        check({pfx, "_ce"},    32'({RAM_LSB_CE, RAM_MSB_CE, RAM_WE}), 32'h0);
        check({pfx, "_addr"},  32'(RAM_ADDR), 32'h0);
    endtask

    initial begin
        int lat, st, t0, wb, hb, hn, lb, mb, ab0;
        logic [7:0] d;
        RSTn = 1'b0; PIX_CEN = 1'b0; BLKn = 1'b1; VID_ADDR = '0;
        CPU_REQ = 1'b0; CPU_RW = 1'b0; CPU_AB = '0; CPU_DIN = '0;
        repeat (3) nxt();
        smp();
        check_reset_outs("rst");

        // Release: pixel slots requested throughout, granted only from the second edge on.
        nxt(); RSTn = 1'b1; PIX_CEN = 1'b1; BLKn = 1'b1; VID_ADDR = 9'h012;
        smp(); check("sync0_ce", 32'({RAM_LSB_CE, RAM_MSB_CE}), 32'h0);
        nxt(); smp(); check("sync1_ce", 32'({RAM_LSB_CE, RAM_MSB_CE}), 32'h0);
        nxt(); smp();
        check("vid_ce", 32'({RAM_LSB_CE, RAM_MSB_CE, RAM_WE}), 32'b110);
        check("vid_addr", 32'(RAM_ADDR), 32'h012);
        nxt(); PIX_CEN = 1'b0; smp(); check("vid_lat1", 32'(VID_DATA), 32'h0);
        nxt(); smp(); check("vid_012", 32'(VID_DATA), 32'h3A5);

        nxt(); PIX_CEN = 1'b1; VID_ADDR = 9'h1FF;
        nxt(); PIX_CEN = 1'b0;
        nxt(); smp(); check("vid_1ff", 32'(VID_DATA), 32'h93C);

        nxt(); PIX_CEN = 1'b1; BLKn = 1'b0; smp();
        check("blank_ce", 32'({RAM_LSB_CE, RAM_MSB_CE}), 32'h0);
        check("idle_addr", 32'(RAM_ADDR), 32'h1FF);
        nxt(); PIX_CEN = 1'b0; smp(); check("blank_lat1", 32'(VID_DATA), 32'h93C);
        nxt(); smp(); check("blank_clr", 32'(VID_DATA), 32'h0);

        // Read during blanking: ISSUE, CAPTURE, ACK.
        nxt(); PIX_CEN = 1'b1; BLKn = 1'b0;
        cpu_xact(1'b1, 10'h010, 8'h00, lat, st, d);
        check("blk_rd_lat", 32'(lat), 32'd3);
        check("blk_rd_stall", 32'(st), 32'd2);
        check("blk_rd_dout", 32'(d), 32'h77);
        check("blk_rd_vdata", 32'(VID_DATA), 32'h0);

        // Three writes against continuous video: stall, forced slots, ordered drain.
        BLKn = 1'b1; VID_ADDR = 9'h012;
        wb = wlog.size(); hb = hold_cyc.size(); t0 = cyc;
        cpu_xact(1'b0, 10'h101, 8'h11, lat, st, d);
        check("w1_lat", 32'(lat), 32'd1); check("w1_stall", 32'(st), 32'd0);
        cpu_xact(1'b0, 10'h302, 8'h22, lat, st, d);
        check("w2_lat", 32'(lat), 32'd1); check("w2_stall", 32'(st), 32'd0);
        cpu_xact(1'b0, 10'h003, 8'h33, lat, st, d);
        check("w3_lat", 32'(lat), 32'd12); check("w3_stall", 32'(st), 32'd11);
        for (int i = 0; i < 100 && wlog.size() < wb + 3; i++) nxt();
        check("w_count", 32'(wlog.size() - wb), 32'd3);
        if (wlog.size() >= wb + 3) begin
            check("w_first_cyc", 32'(wcyc[wb] - t0), 32'd15);
            check("w_order0", 32'(wlog[wb]),     32'({1'b0, 9'h101, 8'h11}));
            check("w_order1", 32'(wlog[wb + 1]), 32'({1'b1, 9'h102, 8'h22}));
            check("w_order2", 32'(wlog[wb + 2]), 32'({1'b0, 9'h003, 8'h33}));
        end
        hn = 0;
        for (int i = hb; i < hold_cyc.size(); i++) if (hold_cyc[i] - t0 <= 20) hn++;
        check("hold_once", 32'(hn), 32'd1);
        if (hold_cyc.size() > hb) check("hold_cyc", 32'(hold_cyc[hb] - t0), 32'd17);
        else check("hold_seen", 32'(hold_cyc.size() - hb), 32'd1);

        // Read-after-write to the MSB bank must wait for the drain.
        wb = wlog.size(); lb = lsb_rd; mb = msb_rd;
        cpu_xact(1'b0, 10'h205, 8'h5A, lat, st, d);
        check("raw_w_lat", 32'(lat), 32'd1);
        t0 = cyc;
        cpu_xact(1'b1, 10'h205, 8'h00, lat, st, d);
        check("raw_dout", 32'(d), 32'h5A);
        check("raw_wcount", 32'(wlog.size() - wb), 32'd1);
        if (wlog.size() > wb) begin
            check("raw_wentry", 32'(wlog[wb]), 32'({1'b1, 9'h005, 8'h5A}));
            check("raw_order", 32'(wcyc[wb] < t0 + lat), 32'd1);
        end
        check("raw_lsb_rd", 32'(lsb_rd - lb), 32'd0);
        check("raw_msb_rd", 32'(msb_rd - mb), 32'd1);

        // Abort a read before it is serviced.
        nxt();
        ab0 = ack_n; lb = lsb_rd; mb = msb_rd;
        CPU_REQ = 1'b1; CPU_RW = 1'b1; CPU_AB = 10'h010;
        repeat (3) nxt();
        CPU_REQ = 1'b0;
        nxt(); smp(); check("abort_waitn", 32'(CPU_WAITn), 32'h1);
        repeat (20) nxt();
        check("abort_ack", 32'(ack_n - ab0), 32'd0);
        check("abort_rd", 32'(lsb_rd - lb + msb_rd - mb), 32'd0);

        // Reset while a read waits behind two buffered writes.
        wb = wlog.size();
        cpu_xact(1'b0, 10'h111, 8'hAA, lat, st, d);
        cpu_xact(1'b0, 10'h312, 8'hBB, lat, st, d);
        CPU_REQ = 1'b1; CPU_RW = 1'b1; CPU_AB = 10'h111;
        repeat (3) nxt();
        smp(); check("drain_waitn", 32'(CPU_WAITn), 32'h0);
        check("drain_nowr", 32'(wlog.size() - wb), 32'd0);
        nxt(); RSTn = 1'b0; CPU_REQ = 1'b0; #1;
        check_reset_outs("mid_rst");
        PIX_CEN = 1'b0;
        repeat (3) nxt();
        RSTn = 1'b1;
        repeat (10) nxt();
        check("rst_discard", 32'(wlog.size() - wb), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
